iob_wrr_arbiter: RTL and testbench
==================================

# iob_wrr_arbiter

Weighted round-robin arbiter for PORTS requesters. Each grant is a tenure of up to `weight[i]` acknowledged transactions, replacing single-shot grants on shared buses such as the Ethernet DMA and buffer-memory ports. Arbitration is rotating-priority, so there is no starvation. Outputs are registered, and the next winner is granted in the cycle after a tenure ends, with no idle bubble.

## Interface
- PORTS, 4: number of requesters (≥2).
- WEIGHT_W, 4: width of each per-port weight field.
- TIMEOUT, 256: maximum tenure length in cycles (≥2). Used only when the timeout feature is compiled in.
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high; has precedence over rst.
- rst  in  1  synchronous reset, active-high; same reset values as arst.
- request  in  PORTS  per-port request level.
- acknowledge  in  PORTS  per-port transaction-complete pulse. Only the bit of the granted port is used.
- weight  in  PORTS*WEIGHT_W  per-port transaction quota. Port i uses bits [i*WEIGHT_W +: WEIGHT_W].
- grant  out  PORTS  one-hot grant.
- grant_valid  out  1  a tenure is active.
- grant_encoded  out  $clog2(PORTS)  index of the granted port.
- timeout_o  out  1  one-cycle pulse when a tenure is forcibly ended.

## Operation
- State: IDLE (grant_valid=0) or GRANT. Internal registers:
  - credit_reg, WEIGHT_W bits.
  - ptr_reg, $clog2(PORTS) bits.
  - tenure counter, $clog2(TIMEOUT+1) bits, present only with the macro.
- Winner search: the first asserted request starting at index ptr_reg and rising with wrap-around, modulo PORTS.
- IDLE → GRANT when any request is high:
  - The winner is granted.
  - credit_reg loads weight[winner]. A weight of 0 is treated as 1.
  - ptr_reg becomes (winner+1) mod PORTS.
- Weight is sampled only at tenure start. Changing weight mid-tenure has no effect until the next tenure.
- A tenure ends in cycle N on any of these events:
  - The granted port's request is low.
  - The granted port's acknowledge is high while credit_reg==1.
  - Timeout (macro builds only).
- An acknowledge with credit_reg>1 decrements credit_reg by 1.
- Acknowledges from non-granted ports are ignored.
- On a tenure end:
  - The winner search uses the request vector of cycle N, with the ending port excluded if its request is low.
  - A sole remaining requester, including the port that just ended, is re-granted with a fresh credit.
  - With no requester, the block returns to IDLE.
- Simultaneous events:
  - A new request arriving in the same cycle as a tenure end takes part in that search.
  - Acknowledge and request-drop in the same cycle count as one end event.

## Timing
- Reset values: grant=0, grant_valid=0, grant_encoded=0, timeout_o=0, ptr_reg=0, credit_reg=0, tenure counter=0.
- arst asynchronously clears all state, including in mid-tenure. Operation resumes from IDLE with ptr_reg=0.
- Request-to-grant latency from IDLE is 1 cycle: request high at N gives grant at N+1.
- End event at N: the next grant, or grant_valid=0, appears at N+1.
- Outputs change only on clk, apart from arst.
- The minimum tenure is 1 cycle.
- A port with weight W and an acknowledge every cycle holds its grant for exactly W cycles.

## Configuration
- IOB_WRR_ARBITER_TIMEOUT_EN defined:
  - The tenure counter starts at 0 in the first grant cycle and increments every GRANT cycle.
  - When it equals TIMEOUT-1 and no other end event occurs in that cycle, the tenure is forcibly ended and re-arbitrated per Operation.
  - timeout_o is 1 in the cycle the following grant or IDLE appears.
- IOB_WRR_ARBITER_TIMEOUT_EN undefined:
  - No counter is built, and timeout_o is tied to 0.
  - A tenure lasts until request drop or credit exhaustion.

## Test plan
- Reset: assert arst during a tenure → all outputs are 0 immediately. After release, request=4'b0100 → grant=4'b0100, grant_encoded=2, grant_valid=1 one cycle later.
- Weighting: weights w0=2, w1=1; request=4'b0011 held; acknowledge=grant every cycle → grant_encoded sequence 0,0,1,0,0,1, with grant_valid held at 1.
- Request drop: port 2 granted with w2=5; port 3 requesting; port 2 drops request after 1 cycle → grant=4'b1000 in the next cycle, with no cycle of grant_valid=0.
- Zero weight and sole requester: w1=0; request=4'b0010; acknowledge=grant every cycle → grant_encoded=1 every cycle, grant_valid stays 1, credit reloaded to 1 each cycle.
- Rotation: all four ports requesting, weights all 1, continuous acknowledge → grant_encoded 0,1,2,3,0. Drop port 1's request mid-sequence → it is skipped.
- Timeout (macro, TIMEOUT=8): port 0 granted and never acknowledges; port 1 requesting → port 0 holds the grant for exactly 8 cycles, then grant_encoded=1 and timeout_o=1 for one cycle.

Source files
------------

// File: rtl/iob_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// iob_wrr_arbiter
//   Weighted round-robin arbiter. A grant is a tenure of up to weight[i]
//   acknowledged transactions. The next winner is searched with rotating
//   priority starting just after the previous winner, so no requester starves.
//   All outputs are registered. The next grant appears in the cycle after a
//   tenure ends, with no idle bubble.
//
//   Optional feature: define IOB_WRR_ARBITER_TIMEOUT_EN to build a tenure
//   counter. It forcibly ends any tenure that lasts TIMEOUT cycles and pulses
//   timeout_o. Without the macro, timeout_o is tied to 0.
//
// Ports
//   clk           clock
//   arst          asynchronous reset, active-high (takes precedence over rst)
//   rst           synchronous reset, active-high
//   request       per-port request level
//   acknowledge   per-port transaction-complete pulse (only the granted bit is used)
//   weight        per-port quota, port i at [i*WEIGHT_W +: WEIGHT_W]; 0 acts as 1
//   grant         one-hot grant
//   grant_valid   a tenure is active
//   grant_encoded index of the granted port
//   timeout_o     one-cycle pulse when a tenure was forcibly ended
// -----------------------------------------------------------------------------
module iob_wrr_arbiter #(
    parameter int PORTS    = 4,
    parameter int WEIGHT_W = 4,
    parameter int TIMEOUT  = 256
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      rst,
    input  logic [PORTS-1:0]          request,
    input  logic [PORTS-1:0]          acknowledge,
    input  logic [PORTS*WEIGHT_W-1:0] weight,
    output logic [PORTS-1:0]          grant,
    output logic                      grant_valid,
    output logic [$clog2(PORTS)-1:0]  grant_encoded,
    output logic                      timeout_o
);

    localparam int IDX_W = $clog2(PORTS);

    if (PORTS < 2 || TIMEOUT < 2) begin : g_param_check
        $error("iob_wrr_arbiter: PORTS and TIMEOUT must both be at least 2");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PORTS-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    enc_q, enc_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;

    logic [IDX_W-1:0]    win;
    logic [WEIGHT_W-1:0] win_weight;
    logic                found;
    logic                drop;
    logic                exhaust;
    logic                to_hit;
    logic                launch;

    // Rotating-priority search: the first request at or above ptr_q, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (!found && request[(int'(ptr_q) + i) % PORTS]) begin
                found = 1'b1;
                win   = IDX_W'((int'(ptr_q) + i) % PORTS);
            end
        end
    end

    assign win_weight = weight[int'(win)*WEIGHT_W +: WEIGHT_W];

    // A request drop and a final acknowledge in the same cycle are one end event.
    assign drop    = !request[enc_q];
    assign exhaust = acknowledge[enc_q] && (credit_q == WEIGHT_W'(1));

    always_comb begin
        // NOTE: every output of this block gets a default before any branch so
        // no path leaves a value unassigned (which would infer a latch).
        state_d  = state_q;
        grant_d  = grant_q;
        enc_d    = enc_q;
        credit_d = credit_q;
        ptr_d    = ptr_q;
        launch   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = found;
            end
            ST_GRANT: begin
                if (drop || exhaust || to_hit) begin
                    launch = found;
                    if (!found) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        enc_d   = '0;
                    end
                end else if (acknowledge[enc_q]) begin
                    // Not exhausted, so credit_q is above 1 here.
                    credit_d = credit_q - WEIGHT_W'(1);
                end
            end
        endcase

        // A new tenure samples its weight here and nowhere else.
        if (launch) begin
            state_d  = ST_GRANT;
            grant_d  = PORTS'(1) << win;
            enc_d    = win;
            credit_d = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
            ptr_d    = IDX_W'((int'(win) + 1) % PORTS);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (arst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            enc_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            enc_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            enc_q    <= enc_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

`ifdef IOB_WRR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // The counter reads 0 in the first grant cycle, so a forced end happens
    // after exactly TIMEOUT grant cycles.
    assign to_hit = (state_q == ST_GRANT) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d     = (state_d == ST_GRANT && !launch) ? cnt_q + CNT_W'(1) : '0;
        timeout_d = to_hit && !drop && !exhaust;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign grant         = grant_q;
    assign grant_valid   = (state_q == ST_GRANT);
    assign grant_encoded = enc_q;

endmodule

// File: tb/tb_iob_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iob_wrr_arbiter
//   Self-checking bench for iob_wrr_arbiter. A transaction-level model (current
//   owner, remaining quota, rotation start) predicts the registered outputs.
//   A compare process checks them on every falling edge. Directed scenarios pin
//   literal expectations, and a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_iob_wrr_arbiter;

    localparam int PORTS    = 4;
    localparam int WEIGHT_W = 4;
    localparam int TIMEOUT  = 8;
`ifdef IOB_WRR_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      arst;
    logic                      rst = 1'b0;
    logic [PORTS-1:0]          request = '0;
    logic [PORTS-1:0]          acknowledge = '0;
    logic [PORTS*WEIGHT_W-1:0] weight = '0;
    logic [PORTS-1:0]          grant;
    logic                      grant_valid;
    logic [1:0]                grant_encoded;
    logic                      timeout_o;

    int errors = 0;
    int checks = 0;

    iob_wrr_arbiter #(
        .PORTS   (PORTS),
        .WEIGHT_W(WEIGHT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .rst          (rst),
        .request      (request),
        .acknowledge  (acknowledge),
        .weight       (weight),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .grant_encoded(grant_encoded),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The tenure owner, remaining quota and next search start are kept as
    // plain integers.
    bit m_valid  = 1'b0;
    int m_cur    = 0;
    int m_credit = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;
    bit m_to     = 1'b0;

    always @(posedge clk or posedge arst) begin : model
        bit nv, nto, ending;
        int nc, ncr, np, nn, w;
        if (arst || rst) begin
            m_valid  <= 1'b0;
            m_cur    <= 0;
            m_credit <= 0;
            m_ptr    <= 0;
            m_cnt    <= 0;
            m_to     <= 1'b0;
        end else begin
            nv = m_valid; nc = m_cur; ncr = m_credit; np = m_ptr;
            nn = m_cnt + 1; nto = 1'b0; ending = 1'b0;
            if (m_valid) begin
                if (!request[m_cur])                                   ending = 1'b1;
                else if (acknowledge[m_cur] && m_credit == 1)          ending = 1'b1;
                else if (TO_EN && m_cnt == TIMEOUT - 1) begin ending = 1'b1; nto = 1'b1; end
                else if (acknowledge[m_cur])                           ncr = m_credit - 1;
            end
            if (!m_valid || ending) begin
                nv = 1'b0;
                nc = 0;
                for (int k = 0; k < PORTS; k++) begin
                    if (request[(m_ptr + k) % PORTS]) begin
                        nv = 1'b1;
                        nc = (m_ptr + k) % PORTS;
                        break;
                    end
                end
                if (nv) begin
                    w   = int'((weight >> (nc * WEIGHT_W)) & 16'hF);
                    ncr = (w == 0) ? 1 : w;
                    np  = (nc + 1) % PORTS;
                    nn  = 0;
                end
            end
            m_valid  <= nv;
            m_cur    <= nc;
            m_credit <= ncr;
            m_ptr    <= np;
            m_cnt    <= nn;
            m_to     <= nto;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_grant;
        if (!arst) begin
            exp_grant = m_valid ? (32'd1 << m_cur) : 32'd0;
            check("model_grant",   {28'd0, grant},          exp_grant);
            check("model_valid",   {31'd0, grant_valid},    {31'd0, m_valid});
            check("model_encoded", {30'd0, grant_encoded},  m_valid ? m_cur : 0);
            check("model_timeout", {31'd0, timeout_o},      {31'd0, m_to});
        end
    end

    // ---------------- helpers ----------------
    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        weight = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst = 1'b1; request = '0; acknowledge = '0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'd0, grant_valid}, 32'd0);
        check("rst_grant", {28'd0, grant}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seq_w[6] = '{0, 0, 1, 0, 0, 1};
        int seq_r[5] = '{0, 1, 2, 3, 0};
        int seq_s[4] = '{2, 3, 0, 2};

        arst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_grant",   {28'd0, grant}, 32'd0);
        check("reset_valid",   {31'd0, grant_valid}, 32'd0);
        check("reset_encoded", {30'd0, grant_encoded}, 32'd0);
        check("reset_timeout", {31'd0, timeout_o}, 32'd0);
        arst = 1'b0;

        // Weighting: w0=2, w1=1, acknowledge every cycle.
        sync_reset();
        set_weights(2, 1, 1, 1);
        request = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wrr_encoded", {30'd0, grant_encoded}, seq_w[i]);
            check("wrr_valid", {31'd0, grant_valid}, 32'd1);
            acknowledge = grant;
        end

        // Request drop: port 2 hands over to port 3 without a bubble.
        sync_reset();
        set_weights(1, 1, 5, 1);
        request = 4'b1100;
        @(negedge clk);
        check("drop_first", {28'd0, grant}, 32'b0100);
        request = 4'b1000;
        @(negedge clk);
        check("drop_next", {28'd0, grant}, 32'b1000);
        check("drop_valid", {31'd0, grant_valid}, 32'd1);

        // Zero weight, sole requester: re-granted every cycle.
        sync_reset();
        set_weights(1, 0, 1, 1);
        request = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("zw_encoded", {30'd0, grant_encoded}, 32'd1);
            check("zw_valid", {31'd0, grant_valid}, 32'd1);
            acknowledge = grant;
        end

        // Rotation, then port 1 drops and is skipped.
        sync_reset();
        set_weights(1, 1, 1, 1);
        request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rot_encoded", {30'd0, grant_encoded}, seq_r[i]);
            acknowledge = grant;
        end
        request = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("skip_encoded", {30'd0, grant_encoded}, seq_s[i]);
            acknowledge = grant;
        end

        // Timeout: port 0 never acknowledges while port 1 waits.
        sync_reset();
        set_weights(3, 3, 3, 3);
        request = 4'b0011;
        if (TO_EN) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                @(negedge clk);
                check("to_hold", {30'd0, grant_encoded}, 32'd0);
                check("to_quiet", {31'd0, timeout_o}, 32'd0);
            end
            @(negedge clk);
            check("to_next", {30'd0, grant_encoded}, 32'd1);
            check("to_pulse", {31'd0, timeout_o}, 32'd1);
            @(negedge clk);
            check("to_pulse_end", {31'd0, timeout_o}, 32'd0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check("noto_hold", {30'd0, grant_encoded}, 32'd0);
                check("noto_quiet", {31'd0, timeout_o}, 32'd0);
            end
        end

        // Asynchronous reset in mid-tenure, then a fresh grant from ptr 0.
        sync_reset();
        set_weights(15, 15, 15, 15);
        request = 4'b1111;
        repeat (3) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        check("arst_grant", {28'd0, grant}, 32'd0);
        check("arst_valid", {31'd0, grant_valid}, 32'd0);
        check("arst_encoded", {30'd0, grant_encoded}, 32'd0);
        @(negedge clk);
        request = 4'b0100;
        arst = 1'b0;
        @(negedge clk);
        check("post_arst_grant", {28'd0, grant}, 32'b0100);
        check("post_arst_encoded", {30'd0, grant_encoded}, 32'd2);
        check("post_arst_valid", {31'd0, grant_valid}, 32'd1);

        // Randomized phase: sticky requests, random acknowledges and weights.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int p = 0; p < PORTS; p++)
                if ($urandom_range(0, 7) == 0) request[p] = ~request[p];
            acknowledge = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 3) == 0) weight = 16'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
